kd11a_upp_seq: RTL

- Microprogram pointer sequencer for the KD11-A base processor with the KE11-E EIS extension attached.
- Holds the 9-bit micro-PC. UPP[8] selects the EIS ROM bank; UPP[7:0] is the address.
- Each micro-cycle it forms the next address from three sources, ORed together: the ROM next-address field, the base-board branch conditions, and the KE11-E branch conditions.
- Sits directly upstream of the EIS board: its eupp output drives that board's ROM, branch decode and timing. Also handles trap-forced jumps and console hold.

---
 rtl/kd11a_upp_seq_if.sv | 45 ++++
 rtl/kd11a_upp_seq.sv | 101 ++++++++++
 2 files changed

// File: rtl/kd11a_upp_seq_if.sv
// rtl/kd11a_upp_seq_if.sv - micro-PC sequencer signal bundle
//
// Purpose: groups the microword, branch, trap and console signals of the
//          KD11-A micro-PC sequencer so they travel as one port.
// Ports (signals of the bundle):
//   clk_u          micro-step strobe (one clk wide)
//   upf[7:0]       next-address field of the current microword
//   ubc[7:0]       base-board branch conditions
//   eubc[8:0]      KE11-E branch conditions; [8] requests EIS ROM entry
//   p_clk_upp8     strobe that returns UPP[8] to the base ROM
//   trap_req       trap request pulse
//   ext_p_clr_trap pending-trap clear
//   hold           console hold
//   eupp[8:0]      current micro-PC {UPP8, UPP[7:0]}
//   pupp[8:0]      micro-PC before the last advance
//   trap_pend      trap pending flag
//   eis_cnt        saturating count of micro-steps spent in the EIS ROM
// Modports: master drives the inputs and observes the outputs,
//           slave is the sequencer itself.
interface kd11a_upp_seq_if #(
  parameter int CNT_W = 8
);
  logic             clk_u;
  logic [7:0]       upf;
  logic [7:0]       ubc;
  logic [8:0]       eubc;
  logic             p_clk_upp8;
  logic             trap_req;
  logic             ext_p_clr_trap;
  logic             hold;
  logic [8:0]       eupp;
  logic [8:0]       pupp;
  logic             trap_pend;
  logic [CNT_W-1:0] eis_cnt;

  modport master (
    output clk_u, upf, ubc, eubc, p_clk_upp8, trap_req, ext_p_clr_trap, hold,
    input  eupp, pupp, trap_pend, eis_cnt
  );

  modport slave (
    input  clk_u, upf, ubc, eubc, p_clk_upp8, trap_req, ext_p_clr_trap, hold,
    output eupp, pupp, trap_pend, eis_cnt
  );
endinterface

// File: rtl/kd11a_upp_seq.sv
// rtl/kd11a_upp_seq.sv - KD11-A micro-PC sequencer with KE11-E EIS bank select
//
// Purpose: holds the 9-bit micro-PC. UPP[8] selects the EIS ROM bank and
//          UPP[7:0] is the ROM address. Each micro-step the next address is
//          the OR of the microword next-address field, the base-board branch
//          conditions and the KE11-E branch conditions. A pending trap forces
//          TRAP_ADDR; console hold freezes the address.
// Ports:
//   i_clk     system clock
//   i_reset   asynchronous active-low reset, released synchronously upstream
//   bus       kd11a_upp_seq_if.slave (see interface file for signal list)
// All outputs come straight from registers.
module kd11a_upp_seq #(
  parameter logic [7:0] RESET_ADDR = 8'o000,
  parameter logic [7:0] TRAP_ADDR  = 8'o016,
  parameter int         CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  kd11a_upp_seq_if.slave   bus
);

  logic [8:0]       r_eupp;
  logic [8:0]       r_pupp;
  logic             r_trap_pend;
  logic [CNT_W-1:0] r_eis_cnt;

  logic             w_adv;
  logic             w_take_trap;
  logic [7:0]       w_or_addr;
  logic             w_upp8_nxt;
  logic             w_eis_entry;
  logic             w_cnt_sat;

  // A micro-step only happens when the strobe is not swallowed by hold;
  // a strobe seen under hold is simply dropped.
  assign w_adv       = bus.clk_u & ~bus.hold;
  assign w_take_trap = w_adv & r_trap_pend;

  // Pure OR of the three sources; the field is 8 bits so no carry/wrap.
  assign w_or_addr   = bus.upf | bus.ubc | bus.eubc[7:0];

  // UPP[8] is sticky once set by eubc[8]; the return strobe beats the set.
  assign w_upp8_nxt  = (r_eupp[8] | bus.eubc[8]) & ~bus.p_clk_upp8;

  // Entering the EIS bank restarts the step counter.
  assign w_eis_entry = w_adv & ~r_trap_pend & ~r_eupp[8] & w_upp8_nxt;
  assign w_cnt_sat   = &r_eis_cnt;

  // Micro-PC and console copy
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_eupp <= {1'b0, RESET_ADDR};
      r_pupp <= 9'd0;
    end else if (w_adv) begin
      r_pupp <= r_eupp;
      if (r_trap_pend) begin
        // Trap entry always lands in the base ROM and ignores branches.
        r_eupp <= {1'b0, TRAP_ADDR};
      end else begin
        r_eupp <= {w_upp8_nxt, w_or_addr};
      end
    end else if (bus.p_clk_upp8) begin
      // Return-to-base works even while held or between micro-steps.
      r_eupp[8] <= 1'b0;
    end
  end

  // Trap pending flag: clear has priority; a request that coincides with
  // the step consuming the flag re-arms it rather than being lost.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_trap_pend <= 1'b0;
    end else if (bus.ext_p_clr_trap) begin
      r_trap_pend <= 1'b0;
    end else if (bus.trap_req) begin
      r_trap_pend <= 1'b1;
    end else if (w_take_trap) begin
      r_trap_pend <= 1'b0;
    end
  end

  // EIS micro-step counter: counts steps taken from the EIS bank, saturates.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_eis_cnt <= '0;
    end else if (w_adv) begin
      if (w_eis_entry) begin
        r_eis_cnt <= '0;
      end else if (r_eupp[8] && !w_cnt_sat) begin
        r_eis_cnt <= r_eis_cnt + 1'b1;
      end
    end
  end

  assign bus.eupp      = r_eupp;
  assign bus.pupp      = r_pupp;
  assign bus.trap_pend = r_trap_pend;
  assign bus.eis_cnt   = r_eis_cnt;

endmodule
